// File: rtl/scroll_executor_pkg.sv
// rtl/scroll_executor_pkg.sv - shared console geometry, scroll request type and engine states
package scroll_executor_pkg;

  localparam int CONSOLE_LINES   = 30;
  localparam int CONSOLE_COLUMNS = 80;
  localparam int CELL_BITS       = 16;
  localparam int RAM_ADDR_BITS   = 12;
  localparam logic [15:0] BLANK_CELL_DEF = 16'h0020;

  // Request handed over by the cursor stage alongside scrollReady.
  typedef struct packed {
    logic       dir;     // 0 = up, 1 = down
    logic [7:0] step;
    logic [7:0] top;
    logic [7:0] bottom;
  } Scrolling_t;

  typedef enum logic [2:0] {
    IDLE,
    COPY,
    DRAIN,
    FILL,
    DONE
  } ScrollState_t;

endpackage

// File: rtl/scroll_executor_addr_gen.sv
// rtl/scroll_executor_addr_gen.sv - row-base plus column walker over a run of whole rows
module scroll_addr_gen #(
  parameter int COLUMNS = 80,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [7:0]        load_rows,
  input  logic              load_dir,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int COL_W = $clog2(COLUMNS);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLUMNS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLUMNS);

  logic [ADDR_W-1:0] base;
  logic [COL_W-1:0]  col;
  logic [7:0]        rows_left;
  logic              dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      col       <= '0;
      rows_left <= '0;
      dir       <= 1'b0;
    end else if (load) begin
      base      <= load_base;
      col       <= '0;
      rows_left <= load_rows;
      dir       <= load_dir;
    end else if (advance) begin
      if (col == COL_MAX) begin
        // Row finished: step the base one row in the walk direction.
        col       <= '0;
        rows_left <= rows_left - 8'd1;
        base      <= dir ? (base - ROW_STEP) : (base + ROW_STEP);
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign addr = base + ADDR_W'(col);
  assign last = (col == COL_MAX) && (rows_left == 8'd1);

endmodule

// File: rtl/scroll_executor.sv
// rtl/scroll_executor.sv - moves whole rows inside the character RAM and blank-fills the vacated rows
module scroll_executor
  import scroll_executor_pkg::*;
#(
  parameter int LINES   = CONSOLE_LINES,
  parameter int COLUMNS = CONSOLE_COLUMNS,
  parameter int CELL_W  = CELL_BITS,
  parameter logic [CELL_W-1:0] BLANK_CELL = CELL_W'(BLANK_CELL_DEF),
  parameter int ADDR_W  = RAM_ADDR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scroll_start,
  input  Scrolling_t        scroll,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [CELL_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [CELL_W-1:0] ram_wdata
);

  localparam logic [ADDR_W-1:0] COLS_VEC = ADDR_W'(COLUMNS);

  // Shift-and-add against the constant COLUMNS; only used when a request is accepted.
  function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (COLS_VEC[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

  ScrollState_t state, next_state;

  logic [7:0] span, n_rows, copy_rows;
  logic [7:0] dst_row, src_row, fill_row;
  logic       degenerate, has_copy, accept;

  logic [7:0]        n_q;
  logic [ADDR_W-1:0] fill_base_q;

  logic              we_q, fill_q, wlast_q, fill_go;
  logic [ADDR_W-1:0] waddr_q;

  logic              src_load, src_last;
  logic [ADDR_W-1:0] src_addr;
  logic              dst_load, dst_dir, dst_adv, dst_last;
  logic [7:0]        dst_rows;
  logic [ADDR_W-1:0] dst_base, dst_addr;
  logic              fill_issue;

  always_comb begin
    span       = scroll.bottom - scroll.top + 8'd1;
    n_rows     = (scroll.step < span) ? scroll.step : span;
    copy_rows  = span - n_rows;
    degenerate = (scroll.step == 8'd0) || (scroll.top > scroll.bottom) ||
                 (scroll.bottom >= 8'(LINES));
    has_copy   = (copy_rows != 8'd0);
    accept     = (state == IDLE) && scroll_start;
    if (!scroll.dir) begin
      dst_row  = scroll.top;
      src_row  = scroll.top + n_rows;
      fill_row = scroll.bottom - n_rows + 8'd1;
    end else begin
      dst_row  = scroll.bottom;
      src_row  = scroll.bottom - n_rows;
      fill_row = scroll.top;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (degenerate)    next_state = DONE;
          else if (has_copy) next_state = COPY;
          else               next_state = FILL;
        end
      end
      COPY:    if (src_last) next_state = DRAIN;
      DRAIN:   next_state = FILL;
      FILL:    if (we_q && wlast_q) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The destination walker is reused for the fill run once the copy run ends.
  always_comb begin
    fill_issue = fill_go && ((state == DRAIN) || (state == FILL));
    src_load   = accept && !degenerate && has_copy;
    dst_load   = (accept && !degenerate) || ((state == COPY) && src_last);
    dst_adv    = (state == COPY) || fill_issue;
    if (accept && has_copy) begin
      dst_base = row_base(dst_row);
      dst_rows = copy_rows;
      dst_dir  = scroll.dir;
    end else if (accept) begin
      dst_base = row_base(fill_row);
      dst_rows = n_rows;
      dst_dir  = 1'b0;
    end else begin
      dst_base = fill_base_q;
      dst_rows = n_q;
      dst_dir  = 1'b0;
    end
  end

  scroll_addr_gen #(.COLUMNS(COLUMNS), .ADDR_W(ADDR_W)) u_src_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (src_load),
    .load_base (row_base(src_row)),
    .load_rows (copy_rows),
    .load_dir  (scroll.dir),
    .advance   (state == COPY),
    .addr      (src_addr),
    .last      (src_last)
  );

  scroll_addr_gen #(.COLUMNS(COLUMNS), .ADDR_W(ADDR_W)) u_dst_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (dst_load),
    .load_base (dst_base),
    .load_rows (dst_rows),
    .load_dir  (dst_dir),
    .advance   (dst_adv),
    .addr      (dst_addr),
    .last      (dst_last)
  );

  // Write stage: every write is staged one cycle before it reaches the RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      fill_q      <= 1'b0;
      wlast_q     <= 1'b0;
      fill_go     <= 1'b0;
      waddr_q     <= '0;
      n_q         <= '0;
      fill_base_q <= '0;
    end else begin
      we_q    <= 1'b0;
      wlast_q <= 1'b0;
      if (accept && !degenerate) begin
        n_q         <= n_rows;
        fill_base_q <= row_base(fill_row);
        fill_go     <= !has_copy;
      end
      if (state == COPY) begin
        we_q    <= 1'b1;
        fill_q  <= 1'b0;
        waddr_q <= dst_addr;
        if (src_last) fill_go <= 1'b1;
      end
      if (fill_issue) begin
        we_q    <= 1'b1;
        fill_q  <= 1'b1;
        waddr_q <= dst_addr;
        wlast_q <= dst_last;
        if (dst_last) fill_go <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign ram_raddr = (state == COPY) ? src_addr : '0;
  assign ram_we    = we_q;
  assign ram_waddr = we_q ? waddr_q : '0;
  assign ram_wdata = !we_q ? '0 : (fill_q ? BLANK_CELL : ram_rdata);

endmodule

// File: tb/tb_scroll_executor.sv
// tb/tb_scroll_executor.sv - scoreboard bench for scroll_executor with a behavioural text RAM
module tb_scroll_executor;
  import scroll_executor_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic        scroll_start;
  Scrolling_t  scroll;
  logic        busy, done, ram_we;
  logic [11:0] ram_raddr, ram_waddr;
  logic [15:0] ram_rdata, ram_wdata;
  logic        preload;

  always #5 clk = ~clk;

  scroll_executor dut (
    .clk          (clk),
    .rst          (rst),
    .scroll_start (scroll_start),
    .scroll       (scroll),
    .busy         (busy),
    .done         (done),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata)
  );

  logic [15:0] mem [0:4095];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
  end

  logic [15:0] ref_mem [0:CELLS-1];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int wr_cnt, done_cyc, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 16'(i);
  endtask

  task automatic push_cell(input int addr, input logic [15:0] data);
    exp_q.push_back({4'h0, 12'(addr), data});
  endtask

  task automatic push_expected(input logic dir, input int step, input int top, input int bottom,
                               output int exp_done, output int exp_wr);
    int span, n;
    exp_q.delete();
    if (step == 0 || top > bottom || bottom >= ROWS) begin
      exp_done = 1;
      exp_wr   = 0;
      return;
    end
    span = bottom - top + 1;
    n    = (step < span) ? step : span;
    if (!dir) begin
      for (int r = top; r <= bottom - n; r++)
        for (int c = 0; c < COLS; c++) push_cell(r * COLS + c, ref_mem[(r + n) * COLS + c]);
      for (int r = bottom - n + 1; r <= bottom; r++)
        for (int c = 0; c < COLS; c++) push_cell(r * COLS + c, 16'h0020);
    end else begin
      for (int r = bottom; r >= top + n; r--)
        for (int c = 0; c < COLS; c++) push_cell(r * COLS + c, ref_mem[(r - n) * COLS + c]);
      for (int r = top; r <= top + n - 1; r++)
        for (int c = 0; c < COLS; c++) push_cell(r * COLS + c, 16'h0020);
    end
    exp_wr   = span * COLS;
    exp_done = span * COLS + 2;
  endtask

  // mode 0: plain run, 1: second start pulsed while busy, 2: reset in cycle 50
  task automatic run(input logic dir, input int step, input int top, input int bottom,
                     input int mode, input string name);
    int exp_done, exp_wr, bad;
    logic [31:0] exp;
    push_expected(dir, step, top, bottom, exp_done, exp_wr);
    wr_cnt   = 0;
    done_cyc = 0;
    done_cnt = 0;
    @(negedge clk);
    scroll       = '{dir: dir, step: 8'(step), top: 8'(top), bottom: 8'(bottom)};
    scroll_start = 1'b1;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      @(negedge clk);
      if (ram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check({name, "_extra_write"}, 32'(ram_waddr), 32'hffff_ffff);
        end else begin
          exp = exp_q.pop_front();
          check({name, "_write"}, {4'h0, ram_waddr, ram_wdata}, exp);
          ref_mem[exp[27:16]] = exp[15:0];
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          check({name, "_busy_at_done"}, 32'(busy), 32'd1);
        end
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) check({name, "_idle_after_done"}, 32'(busy), 32'd0);
      if (mode == 2 && cyc == 51) begin
        check({name, "_we_after_rst"}, 32'(ram_we), 32'd0);
        check({name, "_busy_after_rst"}, 32'(busy), 32'd0);
        rst = 1'b0;
        break;
      end
      if (cyc == 1) scroll_start = 1'b0;
      if (mode == 1 && cyc == 10) scroll_start = 1'b1;
      if (mode == 1 && cyc == 11) scroll_start = 1'b0;
      if (mode == 2 && cyc == 50) rst = 1'b1;
      if (done_cyc != 0 && cyc >= done_cyc + 4) break;
    end
    if (mode == 2) begin
      check({name, "_no_done"}, 32'(done_cnt), 32'd0);
      exp_q.delete();
      return;
    end
    check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({name, "_write_count"}, 32'(wr_cnt), 32'(exp_wr));
    check({name, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({name, "_buffer_cells_wrong"}, 32'(bad), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    scroll_start = 1'b0;
    scroll       = '0;
    preload      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_raddr", 32'(ram_raddr), 32'd0);
    check("rst_waddr", 32'(ram_waddr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    rst = 1'b0;

    do_preload();
    run(1'b0, 1, 0, 29, 0, "up1");
    check("up1_row0_cell0", 32'(mem[0]), 32'd80);
    check("up1_row29_blank", 32'(mem[29 * COLS + 5]), 32'h20);

    do_preload();
    run(1'b1, 2, 5, 10, 0, "down2");
    check("down2_row7", 32'(mem[7 * COLS]), 32'(5 * COLS));
    check("down2_row10", 32'(mem[10 * COLS + 79]), 32'(8 * COLS + 79));
    check("down2_row5_blank", 32'(mem[5 * COLS + 79]), 32'h20);
    check("down2_row4_kept", 32'(mem[4 * COLS + 3]), 32'(4 * COLS + 3));
    check("down2_row11_kept", 32'(mem[11 * COLS]), 32'(11 * COLS));

    do_preload();
    run(1'b0, 40, 3, 6, 0, "clamp");
    check("clamp_row3_blank", 32'(mem[3 * COLS]), 32'h20);

    run(1'b0, 0, 8, 12, 0, "step0");
    run(1'b1, 3, 12, 4, 0, "inverted");
    run(1'b0, 1, 0, 30, 0, "bottom30");

    do_preload();
    run(1'b0, 3, 2, 20, 1, "restart");

    do_preload();
    run(1'b1, 1, 0, 29, 2, "rst_mid");
    run(1'b0, 2, 0, 29, 0, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
